branch_commit_ctrl: RTL and testbench

Commit-side consumer of branch-unit writeback results. Buffers each resolved branch (outcome, taken target, fall-through PC, mismatch flag) by its 4-bit commit-window tag until the ROB head retires that branch. On retirement of a mispredicted branch it pulses the pipeline flush with the redirect PC, then holds fetch for a fixed drain period. Sits between the branch unit's WB stage and the ROB commit stage / front end.

---
 rtl/branch_commit_ctrl.sv | 155 +++++++++++++++
 tb/tb_branch_commit_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_commit_ctrl.sv
// Commit-side branch result buffer: holds resolved branches by commit-window tag,
// trains the predictor on retirement and flushes/redirects on mispredicted retirement.
module branch_commit_ctrl #(
    parameter int WINDOW_BITS  = 4,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   WB_valid,
    input  logic [WINDOW_BITS-1:0] WB_Commit_Window,
    input  logic                   WB_Branch,
    input  logic                   WB_Reserve,
    input  logic [31:0]            WB_Branch_PC,
    input  logic [31:0]            WB_Reserve_PC,
    input  logic                   Commit_valid,
    input  logic                   Commit_is_branch,
    input  logic [WINDOW_BITS-1:0] Commit_Window,
    output logic                   Commit_stall,
    output logic                   flush,
    output logic                   Redirect_valid,
    output logic [31:0]            Redirect_PC,
    output logic                   Fetch_hold,
    output logic                   BP_update_valid,
    output logic                   BP_update_taken,
    output logic [31:0]            BP_update_target,
    output logic                   Err_overwrite
);
    localparam int DEPTH = 1 << WINDOW_BITS;
    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, FLUSH, DRAIN} state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [DEPTH-1:0]   valid_reg;
    logic [DEPTH-1:0]   taken_mem;
    logic [DEPTH-1:0]   mis_mem;
    logic [31:0]        bpc_mem [DEPTH];
    logic [31:0]        rpc_mem [DEPTH];

    logic               flush_reg;
    logic [31:0]        redirect_pc_reg;
    logic               hold_reg;
    logic               bpv_reg;
    logic               bpt_reg;
    logic [31:0]        bptg_reg;
    logic               err_reg;

    logic               idle;
    logic               bypass;
    logic               hit;
    logic               retire_req;
    logic               retire;
    logic               wb_write;
    logic               sel_taken;
    logic               sel_mis;
    logic [31:0]        sel_bpc;
    logic [31:0]        sel_rpc;

    // A same-cycle writeback to the retiring tag is newer than any buffered copy.
    assign idle       = (state_reg == IDLE);
    assign bypass     = WB_valid && (WB_Commit_Window == Commit_Window);
    assign hit        = valid_reg[Commit_Window] || bypass;
    assign retire_req = Commit_valid && Commit_is_branch;
    assign retire     = idle && retire_req && hit;
    assign wb_write   = idle && WB_valid;
    assign sel_taken  = bypass ? WB_Branch     : taken_mem[Commit_Window];
    assign sel_mis    = bypass ? WB_Reserve    : mis_mem[Commit_Window];
    assign sel_bpc    = bypass ? WB_Branch_PC  : bpc_mem[Commit_Window];
    assign sel_rpc    = bypass ? WB_Reserve_PC : rpc_mem[Commit_Window];

    assign Commit_stall = idle ? (retire_req && !hit) : Commit_valid;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Retirement clears after the write so a bypassed entry ends up empty.
            always_ff @(posedge clk) begin
                if (rst || state_reg == FLUSH) begin
                    valid_reg[gi] <= 1'b0;
                end else if (retire && Commit_Window == WINDOW_BITS'(gi)) begin
                    valid_reg[gi] <= 1'b0;
                end else if (wb_write && WB_Commit_Window == WINDOW_BITS'(gi)) begin
                    valid_reg[gi] <= 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (wb_write && WB_Commit_Window == WINDOW_BITS'(gi)) begin
                    taken_mem[gi] <= WB_Branch;
                    mis_mem[gi]   <= WB_Reserve;
                    bpc_mem[gi]   <= WB_Branch_PC;
                    rpc_mem[gi]   <= WB_Reserve_PC;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            flush_reg       <= 1'b0;
            redirect_pc_reg <= 32'd0;
            hold_reg        <= 1'b0;
            bpv_reg         <= 1'b0;
            bpt_reg         <= 1'b0;
            bptg_reg        <= 32'd0;
            err_reg         <= 1'b0;
        end else begin
            flush_reg <= 1'b0;
            bpv_reg   <= 1'b0;
            if (wb_write && valid_reg[WB_Commit_Window]) begin
                err_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (retire) begin
                        bpv_reg  <= 1'b1;
                        bpt_reg  <= sel_taken;
                        bptg_reg <= sel_bpc;
                        if (sel_mis) begin
                            state_reg       <= FLUSH;
                            flush_reg       <= 1'b1;
                            redirect_pc_reg <= sel_taken ? sel_bpc : sel_rpc;
                        end
                    end
                end
                FLUSH: begin
                    state_reg <= DRAIN;
                    cnt_reg   <= CNT_W'(DRAIN_CYCLES);
                    hold_reg  <= 1'b1;
                end
                DRAIN: begin
                    if (cnt_reg <= CNT_W'(1)) begin
                        state_reg <= IDLE;
                        hold_reg  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign flush            = flush_reg;
    assign Redirect_valid   = flush_reg;
    assign Redirect_PC      = redirect_pc_reg;
    assign Fetch_hold       = hold_reg;
    assign BP_update_valid  = bpv_reg;
    assign BP_update_taken  = bpt_reg;
    assign BP_update_target = bptg_reg;
    assign Err_overwrite    = err_reg;
endmodule

// File: tb/tb_branch_commit_ctrl.sv
// Directed plus random stimulus for branch_commit_ctrl against a cycle-level
// behavioural model built from the retirement/flush rules.
module tb_branch_commit_ctrl;
    localparam int WB    = 4;
    localparam int DRAIN = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          WB_valid;
    logic [WB-1:0] WB_Commit_Window;
    logic          WB_Branch;
    logic          WB_Reserve;
    logic [31:0]   WB_Branch_PC;
    logic [31:0]   WB_Reserve_PC;
    logic          Commit_valid;
    logic          Commit_is_branch;
    logic [WB-1:0] Commit_Window;
    logic          Commit_stall;
    logic          flush;
    logic          Redirect_valid;
    logic [31:0]   Redirect_PC;
    logic          Fetch_hold;
    logic          BP_update_valid;
    logic          BP_update_taken;
    logic [31:0]   BP_update_target;
    logic          Err_overwrite;

    branch_commit_ctrl #(.WINDOW_BITS(WB), .DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .rst(rst),
        .WB_valid(WB_valid), .WB_Commit_Window(WB_Commit_Window),
        .WB_Branch(WB_Branch), .WB_Reserve(WB_Reserve),
        .WB_Branch_PC(WB_Branch_PC), .WB_Reserve_PC(WB_Reserve_PC),
        .Commit_valid(Commit_valid), .Commit_is_branch(Commit_is_branch),
        .Commit_Window(Commit_Window), .Commit_stall(Commit_stall),
        .flush(flush), .Redirect_valid(Redirect_valid), .Redirect_PC(Redirect_PC),
        .Fetch_hold(Fetch_hold), .BP_update_valid(BP_update_valid),
        .BP_update_taken(BP_update_taken), .BP_update_target(BP_update_target),
        .Err_overwrite(Err_overwrite)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: buffered branches per tag, plus the number of cycles the controller
    // still refuses work after a mispredict (1 flush cycle + DRAIN hold cycles).
    logic        mv [16];
    logic        mt [16];
    logic        mm [16];
    logic [31:0] mb [16];
    logic [31:0] mr [16];
    int          lock;
    logic        e_err, e_flush, e_hold, e_bpv, e_bpt;
    logic [31:0] e_rpc, e_bptg;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mv[i] = 1'b0;
        lock = 0; e_err = 0; e_flush = 0; e_hold = 0; e_bpv = 0; e_bpt = 0;
        e_rpc = 32'd0; e_bptg = 32'd0;
    endtask

    function automatic logic model_stall();
        if (lock > 0) return Commit_valid;
        return Commit_valid && Commit_is_branch &&
               !(mv[Commit_Window] || (WB_valid && WB_Commit_Window == Commit_Window));
    endfunction

    task automatic model_step();
        logic byp, tk, mis;
        logic [31:0] bpc, rpc;
        if (rst) begin
            model_reset();
            return;
        end
        e_bpv = 0;
        e_flush = 0;
        if (lock == 0) begin
            byp = WB_valid && WB_Commit_Window == Commit_Window;
            tk  = byp ? WB_Branch     : mt[Commit_Window];
            mis = byp ? WB_Reserve    : mm[Commit_Window];
            bpc = byp ? WB_Branch_PC  : mb[Commit_Window];
            rpc = byp ? WB_Reserve_PC : mr[Commit_Window];
            if (Commit_valid && Commit_is_branch && (mv[Commit_Window] || byp)) begin
                e_bpv = 1; e_bpt = tk; e_bptg = bpc;
                if (mis) begin
                    e_flush = 1;
                    e_rpc = tk ? bpc : rpc;
                    lock = 1 + DRAIN;
                end
            end
            if (WB_valid) begin
                if (mv[WB_Commit_Window]) e_err = 1;
                mv[WB_Commit_Window] = 1; mt[WB_Commit_Window] = WB_Branch;
                mm[WB_Commit_Window] = WB_Reserve; mb[WB_Commit_Window] = WB_Branch_PC;
                mr[WB_Commit_Window] = WB_Reserve_PC;
            end
            if (e_bpv) mv[Commit_Window] = 0;
            e_hold = 0;
        end else begin
            if (lock == 1 + DRAIN) for (int i = 0; i < 16; i++) mv[i] = 1'b0;
            lock--;
            e_hold = (lock > 0);
        end
    endtask

    // One clock: drive inputs, check the combinational stall mid-cycle, then the
    // registered outputs just after the edge.
    task automatic cycle(input logic r, input logic wv, input logic [3:0] wt, input logic wbr,
                         input logic wres, input logic [31:0] bpc, input logic [31:0] rpc,
                         input logic cv, input logic cb, input logic [3:0] ct);
        rst = r; WB_valid = wv; WB_Commit_Window = wt; WB_Branch = wbr; WB_Reserve = wres;
        WB_Branch_PC = bpc; WB_Reserve_PC = rpc;
        Commit_valid = cv; Commit_is_branch = cb; Commit_Window = ct;
        @(negedge clk);
        chk("stall", 32'(Commit_stall), 32'(model_stall()));
        @(posedge clk);
        #1;
        model_step();
        chk("flush", 32'(flush), 32'(e_flush));
        chk("redirect_valid", 32'(Redirect_valid), 32'(e_flush));
        chk("redirect_pc", Redirect_PC, e_rpc);
        chk("fetch_hold", 32'(Fetch_hold), 32'(e_hold));
        chk("bp_valid", 32'(BP_update_valid), 32'(e_bpv));
        chk("bp_taken", 32'(BP_update_taken), 32'(e_bpt));
        chk("bp_target", BP_update_target, e_bptg);
        chk("err_overwrite", 32'(Err_overwrite), 32'(e_err));
        $display("t=%0t rst=%0b wb=%0b/%0d cm=%0b%0b/%0d stall=%0b flush=%0b rpc=%0h hold=%0b bpv=%0b tgt=%0h err=%0b",
                 $time, r, wv, wt, cv, cb, ct, Commit_stall, flush, Redirect_PC, Fetch_hold,
                 BP_update_valid, BP_update_target, Err_overwrite);
    endtask

    task automatic nop();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1; WB_valid = 0; WB_Commit_Window = 0; WB_Branch = 0; WB_Reserve = 0;
        WB_Branch_PC = 0; WB_Reserve_PC = 0; Commit_valid = 0; Commit_is_branch = 0;
        Commit_Window = 0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset then idle
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nop();
        chk("idle_flush", 32'(flush), 32'd0);
        chk("idle_bp_target", BP_update_target, 32'd0);
        chk("idle_stall", 32'(Commit_stall), 32'd0);

        // Correct taken branch on tag 3
        cycle(0, 1, 3, 1, 0, 32'h100, 32'h108, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 1, 3);
        chk("t3_bpv", 32'(BP_update_valid), 32'd1);
        chk("t3_taken", 32'(BP_update_taken), 32'd1);
        chk("t3_target", BP_update_target, 32'h100);
        chk("t3_noflush", 32'(flush), 32'd0);
        nop();
        chk("t3_bpv_pulse", 32'(BP_update_valid), 32'd0);

        // Mispredicted not-taken branch on tag 5, WB to tag 6 during drain is dropped
        cycle(0, 1, 5, 0, 1, 32'h200, 32'h48, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 1, 5);
        chk("t5_flush", 32'(flush), 32'd1);
        chk("t5_redirect", Redirect_PC, 32'h48);
        nop();
        chk("t5_hold1", 32'(Fetch_hold), 32'd1);
        cycle(0, 1, 6, 1, 0, 32'h600, 32'h608, 0, 0, 0);
        chk("t5_hold2", 32'(Fetch_hold), 32'd1);
        nop();
        chk("t5_hold_end", 32'(Fetch_hold), 32'd0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 1, 6);
        chk("t6_dropped_stall", 32'(Commit_stall), 32'd1);
        nop();

        // Commit tag 7 waits, then same-cycle bypass
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 1, 7);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 1, 7);
        cycle(0, 1, 7, 1, 0, 32'h700, 32'h708, 1, 1, 7);
        chk("t7_bpv", 32'(BP_update_valid), 32'd1);
        chk("t7_target", BP_update_target, 32'h700);
        nop();

        // Double write to tag 2
        cycle(0, 1, 2, 1, 0, 32'h222, 32'h22a, 0, 0, 0);
        cycle(0, 1, 2, 1, 0, 32'h333, 32'h33b, 0, 0, 0);
        chk("t2_err", 32'(Err_overwrite), 32'd1);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 1, 2);
        chk("t2_latest", BP_update_target, 32'h333);
        nop();
        chk("t2_err_sticky", 32'(Err_overwrite), 32'd1);

        // Reset during the first drain cycle
        cycle(0, 1, 9, 1, 1, 32'h900, 32'h908, 0, 0, 0);
        cycle(0, 1, 4, 0, 0, 32'h400, 32'h408, 1, 1, 9);
        chk("t9_redirect", Redirect_PC, 32'h900);
        nop();
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_hold", 32'(Fetch_hold), 32'd0);
        chk("rst_err", 32'(Err_overwrite), 32'd0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 1, 4);
        chk("rst_table_empty", 32'(Commit_stall), 32'd1);
        nop();

        // Random traffic on a small tag range to force collisions
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 79) == 0),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                  $urandom, $urandom,
                  ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 8),
                  4'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
